trojan_seq: RTL and testbench

- Parametrised, sequential successor to the single-value key-corruption trojan benchmark used in the DES key path.
- Monitors the low MATCH_W bits of a 32-bit trigger bus for an ordered sequence of SEQ_LEN values.
- On a full sequence match, corrupts the key by XOR with FLIP_MASK for HOLD_CYCLES clocks, or until reset when HOLD_CYCLES=0.
- Otherwise passes the key through unchanged.
- Sits between the key register and the DES key-schedule input.

---
 rtl/trojan_seq.sv | 115 +++++++++++
 tb/tb_trojan_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/trojan_seq.sv
// Sequence-triggered key corruption: after SEQ_LEN ordered trigger matches, XORs the key with FLIP_MASK.
// Registered trigger state, combinational payload; no backpressure, trigger sampled only when trig_valid is high.
module trojan_seq #(
  parameter int                          KEY_W        = 56,
  parameter int                          TRIG_W       = 32,
  parameter int                          MATCH_W      = 4,
  parameter int                          SEQ_LEN      = 3,
  parameter logic [SEQ_LEN*MATCH_W-1:0]  SEQ_PATTERNS = 12'h3A5,
  parameter logic [KEY_W-1:0]            FLIP_MASK    = {{(KEY_W-1){1'b0}}, 1'b1},
  parameter int                          HOLD_CYCLES  = 16,
  localparam int                         IDX_W        = $clog2(SEQ_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              trig_valid,
  output logic [KEY_W-1:0]  payload,
  output logic              active,
  output logic [IDX_W-1:0]  match_idx
);

  // Sticky mode still needs a 1-bit counter so the register has a legal width.
  localparam int HCW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HCW-1:0]   HOLD_LOAD = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);
  localparam logic [MATCH_W-1:0] FIRST_ELEM = SEQ_PATTERNS[MATCH_W-1:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MATCHING = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t             state;
  logic [HCW-1:0]     hold_cnt;
  logic [MATCH_W-1:0] cmp_val;
  logic [MATCH_W-1:0] exp_elem;
  logic               hit;
  logic               first_hit;

  assign cmp_val = trigger[MATCH_W-1:0];

  generate
    if (TRIG_W > MATCH_W) begin : g_unused_trig
      logic unused_trig_hi;
      assign unused_trig_hi = ^trigger[TRIG_W-1:MATCH_W];
    end
  endgenerate

  // Select the element expected next; match_idx never exceeds SEQ_LEN-1 outside ACTIVE.
  always_comb begin
    exp_elem = FIRST_ELEM;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (match_idx == IDX_W'(i)) begin
        exp_elem = SEQ_PATTERNS[i*MATCH_W +: MATCH_W];
      end
    end
  end

  assign hit       = (cmp_val == exp_elem);
  assign first_hit = (cmp_val == FIRST_ELEM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_idx <= '0;
      active    <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE, MATCHING: begin
          if (trig_valid) begin
            if (hit) begin
              if (match_idx == LAST_IDX) begin
                state     <= ACTIVE;
                match_idx <= '0;
                active    <= 1'b1;
                hold_cnt  <= HOLD_LOAD;
              end else begin
                state     <= MATCHING;
                match_idx <= match_idx + IDX_W'(1);
              end
            end else if (first_hit) begin
              // A broken sequence may itself be the start of a new one.
              state     <= MATCHING;
              match_idx <= IDX_W'(1);
            end else begin
              state     <= IDLE;
              match_idx <= '0;
            end
          end
        end
        ACTIVE: begin
          if (HOLD_CYCLES != 0) begin
            if (hold_cnt == '0) begin
              state  <= IDLE;
              active <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HCW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          match_idx <= '0;
          active    <= 1'b0;
        end
      endcase
    end
  end

  assign payload = active ? (key ^ FLIP_MASK) : key;

endmodule

// File: tb/tb_trojan_seq.sv
// Directed bench for trojan_seq: default sequence/hold instance plus a sticky single-element instance.
module tb_trojan_seq;

  logic        clk;
  logic        rst_n;
  logic [55:0] key;
  logic [31:0] trigger;
  logic        trig_valid;
  logic [55:0] payload;
  logic        active;
  logic [1:0]  match_idx;

  logic        rst2_n;
  logic [55:0] key2;
  logic [31:0] trigger2;
  logic        valid2;
  logic [55:0] payload2;
  logic        active2;
  logic [0:0]  idx2;

  int checks = 0;
  int errors = 0;

  localparam logic [55:0] KEY_A  = 56'h0123456789ABCD;
  localparam logic [55:0] KEY_AX = 56'h0123456789ABCC;
  localparam logic [55:0] KEY_B  = 56'hFEDCBA98765432;
  localparam logic [55:0] KEY_BX = 56'hFEDCBA98765433;

  trojan_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .trigger    (trigger),
    .trig_valid (trig_valid),
    .payload    (payload),
    .active     (active),
    .match_idx  (match_idx)
  );

  trojan_seq #(
    .SEQ_LEN      (1),
    .SEQ_PATTERNS (4'h5),
    .HOLD_CYCLES  (0)
  ) dut_sticky (
    .clk        (clk),
    .rst_n      (rst2_n),
    .key        (key2),
    .trigger    (trigger2),
    .trig_valid (valid2),
    .payload    (payload2),
    .active     (active2),
    .match_idx  (idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one sample with random upper trigger bits, then step past the next rising edge.
  task automatic samp(input logic [3:0] nib, input logic v);
    logic [31:0] r;
    r = $urandom();
    trigger    = {r[31:4], nib};
    trig_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic samp2(input logic [3:0] nib, input logic v);
    logic [31:0] r;
    r = $urandom();
    trigger2 = {r[31:4], nib};
    valid2   = v;
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse between edges; outputs must revert before any clock.
  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_active"}, 64'(active), 64'(1'b0));
    chk({tag, "_payload"}, 64'(payload), 64'(KEY_A));
    chk({tag, "_idx"}, 64'(match_idx), 64'(2'd0));
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    key = KEY_A; key2 = KEY_B;
    trigger = '0; trig_valid = 1'b0;
    trigger2 = '0; valid2 = 1'b0;
    #2;
    chk("rst_active", 64'(active), 64'(1'b0));
    chk("rst_idx", 64'(match_idx), 64'(2'd0));
    chk("rst_payload", 64'(payload), 64'(KEY_A));
    chk("rst2_payload", 64'(payload2), 64'(KEY_B));
    #10 rst_n = 1'b1; rst2_n = 1'b1;

    // Basic 5, A, 3 sequence
    samp(4'h5, 1'b1); chk("seq1_idx", 64'(match_idx), 64'(2'd1)); chk("seq1_act", 64'(active), 64'(1'b0));
    samp(4'hA, 1'b1); chk("seq2_idx", 64'(match_idx), 64'(2'd2)); chk("seq2_act", 64'(active), 64'(1'b0));
    samp(4'h3, 1'b1);
    chk("seq3_act", 64'(active), 64'(1'b1));
    chk("seq3_payload", 64'(payload), 64'(KEY_AX));
    chk("seq3_idx", 64'(match_idx), 64'(2'd0));

    // Hold for 16 clocks total; re-presenting the sequence during ACTIVE has no effect.
    samp(4'h5, 1'b1); chk("hold1", 64'(active), 64'(1'b1));
    samp(4'hA, 1'b1); chk("hold2", 64'(active), 64'(1'b1));
    samp(4'h3, 1'b1); chk("hold3", 64'(active), 64'(1'b1));
    chk("hold3_idx", 64'(match_idx), 64'(2'd0));
    for (int i = 4; i <= 15; i++) begin
      samp(4'h0, 1'b0);
      chk("hold_n", 64'(active), 64'(1'b1));
      chk("hold_payload", 64'(payload), 64'(KEY_AX));
    end
    // Exit edge: a valid 5 here must not be evaluated.
    samp(4'h5, 1'b1);
    chk("exit_act", 64'(active), 64'(1'b0));
    chk("exit_payload", 64'(payload), 64'(KEY_A));
    chk("exit_idx", 64'(match_idx), 64'(2'd0));

    // 5, 7, 5, A, 3
    samp(4'h5, 1'b1); chk("brk1_idx", 64'(match_idx), 64'(2'd1));
    samp(4'h7, 1'b1); chk("brk2_idx", 64'(match_idx), 64'(2'd0));
    samp(4'h5, 1'b1); chk("brk3_idx", 64'(match_idx), 64'(2'd1));
    samp(4'hA, 1'b1); chk("brk4_idx", 64'(match_idx), 64'(2'd2)); chk("brk4_act", 64'(active), 64'(1'b0));
    samp(4'h3, 1'b1); chk("brk5_act", 64'(active), 64'(1'b1));

    pulse_reset("rst_mid_active");

    // 5, 5, A, 3 with restart credit
    samp(4'h5, 1'b1); chk("rc1_idx", 64'(match_idx), 64'(2'd1));
    samp(4'h5, 1'b1); chk("rc2_idx", 64'(match_idx), 64'(2'd1));
    samp(4'hA, 1'b1); chk("rc3_idx", 64'(match_idx), 64'(2'd2));
    samp(4'h3, 1'b1); chk("rc4_act", 64'(active), 64'(1'b1)); chk("rc4_payload", 64'(payload), 64'(KEY_AX));

    pulse_reset("rst_after_rc");

    // Invalid samples do not break the sequence.
    samp(4'h5, 1'b1); chk("gap1_idx", 64'(match_idx), 64'(2'd1));
    for (int i = 0; i < 3; i++) begin
      samp(4'hF, 1'b0);
      chk("gap_hold_idx", 64'(match_idx), 64'(2'd1));
      chk("gap_hold_act", 64'(active), 64'(1'b0));
    end
    samp(4'hA, 1'b1); chk("gap2_idx", 64'(match_idx), 64'(2'd2));
    samp(4'h3, 1'b1); chk("gap3_act", 64'(active), 64'(1'b1));

    pulse_reset("rst_after_gap");

    // Sticky single-element instance: upper trigger bits must not matter.
    trigger2 = 32'h5555_5557; valid2 = 1'b1;
    @(posedge clk); #1;
    chk("st_nomatch_act", 64'(active2), 64'(1'b0));
    chk("st_nomatch_idx", 64'(idx2), 64'(1'b0));
    samp2(4'h5, 1'b1);
    chk("st_act", 64'(active2), 64'(1'b1));
    chk("st_payload", 64'(payload2), 64'(KEY_BX));
    for (int i = 0; i < 120; i++) begin
      samp2(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      chk("st_sticky", 64'(active2), 64'(1'b1));
    end
    chk("st_payload_late", 64'(payload2), 64'(KEY_BX));
    #1 rst2_n = 1'b0;
    #1;
    chk("st_rst_act", 64'(active2), 64'(1'b0));
    chk("st_rst_payload", 64'(payload2), 64'(KEY_B));
    #1 rst2_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
